// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory port arbiter:
//   arb_state_e  - arbiter FSM state (pipeline-priority / locked loader burst)
//   rd_owner_e   - which requester owns the read data returning next cycle
//   mem_req_t    - one memory request as seen by the port mux
//   req_normalize- collapses a simultaneous read+write into a pure write
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int ARB_ADDR_W = 9;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [0:0] {
        S_PIPE = 1'b0,
        S_LOAD = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_LOAD = 2'd2
    } rd_owner_e;

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [2:0]            func3;
    } mem_req_t;

    // A request carrying both rd and wr is treated as a write only.
    function automatic mem_req_t req_normalize(input mem_req_t req);
        mem_req_t res;
        res    = req;
        res.rd = req.rd & ~req.wr;
        return res;
    endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// -----------------------------------------------------------------------------
// arb_sat_counter
// Saturating up-counter with clear, used for the loader wait and burst counts.
//   clk_i   - clock
//   rst_n_i - asynchronous active-low reset (count -> 0)
//   clr_i   - clear; together with inc_i the count restarts at 1
//   inc_i   - increment, holds at MAX once reached
//   cnt_o   - current count
// -----------------------------------------------------------------------------
module arb_sat_counter #(
    parameter int          WIDTH = 4,
    parameter int unsigned MAX   = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear+inc starts a new run at 1, otherwise saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i && inc_i) begin
            cnt_d = CNT_ONE;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the pipeline MEM stage and the
// debug/program loader. The pipeline has priority; a starvation counter forces
// the loader in after MAX_WAIT denied cycles, and locked loader bursts are
// capped at MAX_BURST beats.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   p_rd/p_wr/p_addr/p_wdata/p_func3 - pipeline request
//   p_stall, p_rdata     - pipeline not granted / read data (cycle after grant)
//   l_req/l_we/l_lock/l_addr/l_wdata/l_func3 - loader request
//   l_gnt, l_rvalid, l_rdata - loader beat accepted / read return
//   m_rd/m_wr/m_addr/m_wdata/m_func3 - memory port, m_rdata - memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int MAX_WAIT   = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p_rd,
    input  logic                  p_wr,
    input  logic [DM_ADDRESS-1:0] p_addr,
    input  logic [DATA_W-1:0]     p_wdata,
    input  logic [2:0]            p_func3,
    output logic                  p_stall,
    output logic [DATA_W-1:0]     p_rdata,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic                  l_lock,
    input  logic [DM_ADDRESS-1:0] l_addr,
    input  logic [DATA_W-1:0]     l_wdata,
    input  logic [2:0]            l_func3,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    output logic [DATA_W-1:0]     l_rdata,
    output logic                  m_rd,
    output logic                  m_wr,
    output logic [DM_ADDRESS-1:0] m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [2:0]            m_func3,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);

    arb_state_e  state_q;
    arb_state_e  state_d;
    rd_owner_e   rd_owner_q;
    rd_owner_e   rd_owner_d;

    logic [WAIT_W-1:0] wait_cnt_s;
    logic [BEAT_W-1:0] beat_cnt_s;

    logic     pipe_req_s;
    logic     burst_cont_s;
    logic     burst_end_s;
    logic     gnt_p_s;
    logic     gnt_l_s;
    mem_req_t p_req_s;
    mem_req_t l_req_s;
    mem_req_t sel_s;

    assign pipe_req_s   = p_rd | p_wr;
    // A locked burst keeps the port while it stays under the beat cap.
    assign burst_cont_s = (state_q == S_LOAD) && l_req && l_lock && (beat_cnt_s < BEAT_MAX);
    // A burst that ran to the cap must yield to a waiting pipeline request.
    assign burst_end_s  = (state_q == S_LOAD) && (beat_cnt_s == BEAT_MAX);

    // Grant decision from current state, counters and requests.
    always_comb begin
        gnt_p_s = 1'b0;
        gnt_l_s = 1'b0;
        if (burst_cont_s) begin
            gnt_l_s = 1'b1;
        end else if (l_req && (wait_cnt_s == WAIT_MAX) && !(burst_end_s && pipe_req_s)) begin
            gnt_l_s = 1'b1;
        end else if (pipe_req_s) begin
            gnt_p_s = 1'b1;
        end else if (l_req && !(burst_end_s && pipe_req_s)) begin
            gnt_l_s = 1'b1;
        end else begin
            gnt_p_s = 1'b0;
            gnt_l_s = 1'b0;
        end
    end

    // Next state and owner of the read data returning next cycle.
    always_comb begin
        state_d = (gnt_l_s && l_lock) ? S_LOAD : S_PIPE;
        if (gnt_l_s && !l_we) begin
            rd_owner_d = OWN_LOAD;
        end else if (gnt_p_s && p_rd && !p_wr) begin
            rd_owner_d = OWN_PIPE;
        end else begin
            rd_owner_d = OWN_NONE;
        end
    end

    // Arbiter FSM and read-owner register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_PIPE;
            rd_owner_q <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Denied loader cycles; cleared on a loader grant or when the loader is idle.
    arb_sat_counter #(
        .WIDTH (WAIT_W),
        .MAX   (MAX_WAIT)
    ) u_wait_cnt (
        .clk_i   (clk),
        .rst_n_i (reset),
        .clr_i   (gnt_l_s | ~l_req),
        .inc_i   (l_req & ~gnt_l_s),
        .cnt_o   (wait_cnt_s)
    );

    // Locked beats in the current burst; a fresh locked grant restarts at 1.
    arb_sat_counter #(
        .WIDTH (BEAT_W),
        .MAX   (MAX_BURST)
    ) u_beat_cnt (
        .clk_i   (clk),
        .rst_n_i (reset),
        .clr_i   (~burst_cont_s),
        .inc_i   (gnt_l_s & l_lock),
        .cnt_o   (beat_cnt_s)
    );

    // Memory port mux; with no grant the pipeline request is presented with enables low.
    always_comb begin
        p_req_s = req_normalize(mem_req_t'{rd: p_rd, wr: p_wr, addr: p_addr,
                                           wdata: p_wdata, func3: p_func3});
        l_req_s = mem_req_t'{rd: ~l_we, wr: l_we, addr: l_addr,
                             wdata: l_wdata, func3: l_func3};
        if (gnt_l_s) begin
            sel_s = l_req_s;
        end else begin
            sel_s = p_req_s;
        end
        m_rd    = (gnt_p_s | gnt_l_s) & sel_s.rd;
        m_wr    = (gnt_p_s | gnt_l_s) & sel_s.wr;
        m_addr  = sel_s.addr;
        m_wdata = sel_s.wdata;
        m_func3 = sel_s.func3;
        p_stall = pipe_req_s & ~gnt_p_s;
        l_gnt   = gnt_l_s;
    end

    // Route the returning read data to its owner only.
    always_comb begin
        p_rdata  = '0;
        l_rdata  = '0;
        l_rvalid = 1'b0;
        case (rd_owner_q)
            OWN_PIPE: begin
                p_rdata = m_rdata;
            end
            OWN_LOAD: begin
                l_rdata  = m_rdata;
                l_rvalid = 1'b1;
            end
            default: begin
                p_rdata  = '0;
                l_rdata  = '0;
                l_rvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        p_rd, p_wr;
    logic [8:0]  p_addr;
    logic [31:0] p_wdata;
    logic [2:0]  p_func3;
    logic        p_stall;
    logic [31:0] p_rdata;
    logic        l_req, l_we, l_lock;
    logic [8:0]  l_addr;
    logic [31:0] l_wdata;
    logic [2:0]  l_func3;
    logic        l_gnt, l_rvalid;
    logic [31:0] l_rdata;
    logic        m_rd, m_wr;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_func3;
    logic [31:0] m_rdata;

    localparam logic [31:0] D010 = 32'hDEADBEEF;
    localparam logic [31:0] D004 = 32'hA4A40004;
    localparam logic [31:0] D008 = 32'hC8C80008;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural data memory with a preload port
    logic [31:0] mem [0:511];
    logic        pl_en;
    logic [8:0]  pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (m_wr) mem[m_addr] <= m_wdata;
        if (m_rd) m_rdata <= mem[m_addr];
    end

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata), .p_func3(p_func3),
        .p_stall(p_stall), .p_rdata(p_rdata),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_func3(l_func3), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_func3(m_func3),
        .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        p_rd = 1'b0; p_wr = 1'b0; p_addr = 9'h000; p_wdata = 32'h0; p_func3 = 3'b010;
        l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = 9'h000; l_wdata = 32'h0;
        l_func3 = 3'b001;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; idle(); pl_en = 1'b0; pl_addr = 9'h000; pl_data = 32'h0;
        next_cycle();
        pl_en = 1'b1; pl_addr = 9'h010; pl_data = D010; next_cycle();
        pl_addr = 9'h004; pl_data = D004; next_cycle();
        pl_addr = 9'h008; pl_data = D008; next_cycle();
        pl_en = 1'b0;
        @(negedge clk);
        n_tests++; if (l_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_l_rvalid: got %b want 0", l_rvalid); end
        n_tests++; if (p_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_p_rdata: got %h want 0", p_rdata); end
        n_tests++; if (l_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_l_rdata: got %h want 0", l_rdata); end
        n_tests++; if ({m_rd, m_wr, l_gnt, p_stall} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {m_rd, m_wr, l_gnt, p_stall}); end
        next_cycle();
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_pipe_read();
        idle(); p_rd = 1'b1; p_addr = 9'h010;
        @(negedge clk);
        n_tests++; if ({m_rd, m_wr, p_stall, l_gnt} !== 4'b1000) begin n_fail++; $display("FAIL pread_ctrl: got %b want 1000", {m_rd, m_wr, p_stall, l_gnt}); end
        n_tests++; if (m_addr !== 9'h010 || m_func3 !== 3'b010) begin n_fail++; $display("FAIL pread_addr: got %h/%b want 010/010", m_addr, m_func3); end
        sb.push_back('{1'b0, D010});
        next_cycle();
        idle();
        @(negedge clk);
        e = sb.pop_front();
        n_tests++; if (p_rdata !== e.data || l_rvalid !== 1'b0) begin n_fail++; $display("FAIL pread_data: got %h rv %b want %h rv 0", p_rdata, l_rvalid, e.data); end
        n_tests++; if (p_stall !== 1'b0) begin n_fail++; $display("FAIL pread_stall: got %b want 0", p_stall); end
        next_cycle();
    endtask

    task automatic test_starvation();
        logic exp_g;
        idle(); l_req = 1'b1; l_we = 1'b1; l_addr = 9'h020; l_wdata = 32'h00001234;
        for (int c = 1; c <= 5; c++) begin
            p_wr = 1'b1; p_addr = 9'h100 + 9'(c); p_wdata = 32'(c);
            @(negedge clk);
            exp_g = (c == 5);
            n_tests++; if (l_gnt !== exp_g || p_stall !== exp_g) begin n_fail++; $display("FAIL starve_c%0d: gnt %b stall %b want %b %b", c, l_gnt, p_stall, exp_g, exp_g); end
            n_tests++; if (m_wr !== 1'b1 || m_addr !== (exp_g ? 9'h020 : 9'h100 + 9'(c))) begin n_fail++; $display("FAIL starve_addr_c%0d: wr %b addr %h", c, m_wr, m_addr); end
            next_cycle();
            if (exp_g) l_req = 1'b0;
        end
        idle(); p_rd = 1'b1; p_addr = 9'h020;
        @(negedge clk);
        sb.push_back('{1'b0, 32'h00001234});
        next_cycle();
        idle();
        @(negedge clk);
        e = sb.pop_front();
        n_tests++; if (p_rdata !== e.data) begin n_fail++; $display("FAIL starve_readback: got %h want %h", p_rdata, e.data); end
        n_tests++; if (mem[9'h104] !== 32'h4) begin n_fail++; $display("FAIL starve_pipe_wr: got %h want 4", mem[9'h104]); end
        next_cycle();
    endtask

    task automatic test_burst();
        logic exp_g, exp_s;
        int   b;
        idle(); b = 0;
        for (int c = 1; c <= 11; c++) begin
            l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1;
            l_addr = 9'h080 + 9'(b); l_wdata = 32'h0000B000 + 32'(b);
            p_wr = (c >= 3 && c <= 9); p_addr = 9'h0C0; p_wdata = 32'h0000C0C0;
            @(negedge clk);
            exp_g = (c != 9);
            exp_s = (c >= 3 && c <= 8);
            n_tests++; if (l_gnt !== exp_g || p_stall !== exp_s) begin n_fail++; $display("FAIL burst_c%0d: gnt %b stall %b want %b %b", c, l_gnt, p_stall, exp_g, exp_s); end
            next_cycle();
            if (exp_g) b++;
        end
        idle();
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            n_tests++; if (mem[9'h080 + 9'(i)] !== 32'h0000B000 + 32'(i)) begin n_fail++; $display("FAIL burst_mem%0d: got %h want %h", i, mem[9'h080 + 9'(i)], 32'h0000B000 + 32'(i)); end
        end
        n_tests++; if (mem[9'h0C0] !== 32'h0000C0C0) begin n_fail++; $display("FAIL burst_pipe_mem: got %h want c0c0", mem[9'h0C0]); end
    endtask

    task automatic test_alternate();
        idle(); l_req = 1'b1; l_we = 1'b0; l_addr = 9'h004;
        @(negedge clk);
        n_tests++; if ({l_gnt, m_rd, m_wr} !== 3'b110 || m_addr !== 9'h004 || m_func3 !== 3'b001) begin n_fail++; $display("FAIL alt_lgrant: got %b addr %h f3 %b", {l_gnt, m_rd, m_wr}, m_addr, m_func3); end
        sb.push_back('{1'b1, D004});
        next_cycle();
        idle(); p_rd = 1'b1; p_addr = 9'h008;
        @(negedge clk);
        e = sb.pop_front();
        n_tests++; if (l_rvalid !== e.is_load || l_rdata !== e.data || p_rdata !== 32'h0) begin n_fail++; $display("FAIL alt_lret: rv %b l %h p %h want 1 %h 0", l_rvalid, l_rdata, p_rdata, e.data); end
        n_tests++; if (m_rd !== 1'b1 || p_stall !== 1'b0 || m_addr !== 9'h008) begin n_fail++; $display("FAIL alt_pgrant: rd %b stall %b addr %h", m_rd, p_stall, m_addr); end
        sb.push_back('{1'b0, D008});
        next_cycle();
        idle();
        @(negedge clk);
        e = sb.pop_front();
        n_tests++; if (p_rdata !== e.data || l_rvalid !== e.is_load || l_rdata !== 32'h0) begin n_fail++; $display("FAIL alt_pret: p %h rv %b l %h want %h 0 0", p_rdata, l_rvalid, l_rdata, e.data); end
        next_cycle();
    endtask

    task automatic test_rd_wr_both();
        idle(); p_rd = 1'b1; p_wr = 1'b1; p_addr = 9'h030; p_wdata = 32'h00000055;
        @(negedge clk);
        n_tests++; if ({m_wr, m_rd, p_stall} !== 3'b100 || m_wdata !== 32'h55) begin n_fail++; $display("FAIL both_ctrl: wr %b rd %b stall %b data %h", m_wr, m_rd, p_stall, m_wdata); end
        next_cycle();
        idle();
        @(negedge clk);
        n_tests++; if (mem[9'h030] !== 32'h00000055) begin n_fail++; $display("FAIL both_mem: got %h want 55", mem[9'h030]); end
        n_tests++; if (p_rdata !== 32'h0) begin n_fail++; $display("FAIL both_noret: got %h want 0", p_rdata); end
        next_cycle();
    endtask

    task automatic test_reset_burst();
        idle(); l_req = 1'b1; l_we = 1'b0; l_lock = 1'b1; l_addr = 9'h004;
        @(negedge clk);
        n_tests++; if (l_gnt !== 1'b1 || m_rd !== 1'b1) begin n_fail++; $display("FAIL rb_beat1: gnt %b rd %b want 1 1", l_gnt, m_rd); end
        next_cycle();
        l_addr = 9'h008;
        @(negedge clk);
        n_tests++; if (l_gnt !== 1'b1 || l_rvalid !== 1'b1 || l_rdata !== D004) begin n_fail++; $display("FAIL rb_beat2: gnt %b rv %b data %h", l_gnt, l_rvalid, l_rdata); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_tests++; if (l_rvalid !== 1'b0 || l_rdata !== 32'h0) begin n_fail++; $display("FAIL rb_drop: rv %b data %h want 0 0", l_rvalid, l_rdata); end
        next_cycle();
        reset = 1'b1; p_rd = 1'b1; p_addr = 9'h008;
        @(negedge clk);
        n_tests++; if (p_stall !== 1'b0 || l_gnt !== 1'b0 || m_addr !== 9'h008) begin n_fail++; $display("FAIL rb_pipe_first: stall %b gnt %b addr %h", p_stall, l_gnt, m_addr); end
        sb.push_back('{1'b0, D008});
        next_cycle();
        idle();
        @(negedge clk);
        e = sb.pop_front();
        n_tests++; if (p_rdata !== e.data || l_rvalid !== 1'b0) begin n_fail++; $display("FAIL rb_pret: got %h rv %b want %h 0", p_rdata, l_rvalid, e.data); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_pipe_read();
        test_starvation();
        test_burst();
        test_alternate();
        test_rd_wr_both();
        test_reset_burst();
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: %0d entries want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
